// File: rtl/call_pkg.sv
// Shared types and default sizing for the call dispatcher slice.
package call_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD
    } call_state_t;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_TIMEOUT = 1000;

endpackage

// File: rtl/call_dispatcher_if.sv
// Argument stream, callee start/done port and result stream of the dispatcher.
interface call_dispatcher_if import call_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;

    logic             call_start;
    logic [WIDTH-1:0] call_a;
    logic [WIDTH-1:0] call_b;
    logic [WIDTH-1:0] call_result;
    logic             call_done;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_error;

    logic             busy;

    modport slave (
        input  in_valid, in_a, in_b, call_result, call_done, out_ready,
        output in_ready, call_start, call_a, call_b,
               out_valid, out_result, out_error, busy
    );

    modport master (
        output in_valid, in_a, in_b, call_result, call_done, out_ready,
        input  in_ready, call_start, call_a, call_b,
               out_valid, out_result, out_error, busy
    );

endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO holding packed argument pairs; head is readable without latency.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign head    = mem[rd_ptr_reg];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage is not reset: a flush only clears the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/call_dispatcher.sv
// Buffers argument pairs and runs them one at a time through a start/done callee.
module call_dispatcher import call_pkg::*; #(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    call_dispatcher_if.slave  bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    call_state_t               state_reg;
    logic [CW-1:0]             wait_cnt_reg;
    logic [CW-1:0]             wait_cnt_inc;
    logic                      call_start_reg;
    logic [WIDTH-1:0]          call_a_reg;
    logic [WIDTH-1:0]          call_b_reg;
    logic                      out_valid_reg;
    logic [WIDTH-1:0]          out_result_reg;
    logic                      out_error_reg;

    logic [2*WIDTH-1:0]        fifo_head;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [$clog2(DEPTH):0]    fifo_count;

    sync_fifo #(
        .WIDTH (2*WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (bus.in_valid),
        .push_data ({bus.in_a, bus.in_b}),
        .pop       (state_reg == ISSUE),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign bus.in_ready   = !fifo_full;
    assign bus.busy       = (state_reg != IDLE) || (fifo_count != '0);
    assign bus.call_start = call_start_reg;
    assign bus.call_a     = call_a_reg;
    assign bus.call_b     = call_b_reg;
    assign bus.out_valid  = out_valid_reg;
    assign bus.out_result = out_result_reg;
    assign bus.out_error  = out_error_reg;

    assign wait_cnt_inc = (wait_cnt_reg == CW'(TIMEOUT)) ? wait_cnt_reg : wait_cnt_reg + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= IDLE;
            wait_cnt_reg   <= '0;
            call_start_reg <= 1'b0;
            call_a_reg     <= '0;
            call_b_reg     <= '0;
            out_valid_reg  <= 1'b0;
            out_result_reg <= '0;
            out_error_reg  <= 1'b0;
        end else begin
            call_start_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (!fifo_empty) begin
                        state_reg <= ISSUE;
                    end
                end
                ISSUE: begin
                    call_start_reg            <= 1'b1;
                    {call_a_reg, call_b_reg}  <= fifo_head;
                    wait_cnt_reg              <= '0;
                    state_reg                 <= WAIT;
                end
                WAIT: begin
                    wait_cnt_reg <= wait_cnt_inc;
                    // Done seen in the first WAIT cycle may be left over from the previous call.
                    if ((wait_cnt_reg != '0) && bus.call_done) begin
                        out_result_reg <= bus.call_result;
                        out_error_reg  <= 1'b0;
                        out_valid_reg  <= 1'b1;
                        state_reg      <= HOLD;
                    end else if (wait_cnt_inc == CW'(TIMEOUT)) begin
                        out_result_reg <= '0;
                        out_error_reg  <= 1'b1;
                        out_valid_reg  <= 1'b1;
                        state_reg      <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_call_dispatcher.sv
// Scoreboard bench for call_dispatcher driving a multiplier-style start/done callee.
module tb_call_dispatcher;
    import call_pkg::*;

    localparam int WIDTH   = 32;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 1000;
    localparam int LAT     = 3;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             err;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    bit   mute  = 1'b0;

    exp_t               exp_q[$];
    logic [2*WIDTH-1:0] op_q[$];
    int total   = 0;
    int bad     = 0;
    int n_start = 0;

    always #5 clk = ~clk;

    call_dispatcher_if #(.WIDTH(WIDTH)) bus ();

    call_dispatcher #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Callee: result after LAT cycles, done held until the next start; mute suppresses done.
    logic [WIDTH-1:0] ce_a, ce_b;
    int               ce_cnt;
    bit               ce_run;
    always @(posedge clk) begin
        if (!reset) begin
            bus.call_done   <= 1'b0;
            bus.call_result <= '0;
            ce_run          <= 1'b0;
            ce_cnt          <= 0;
        end else if (bus.call_start) begin
            bus.call_done <= 1'b0;
            ce_a          <= bus.call_a;
            ce_b          <= bus.call_b;
            ce_run        <= 1'b1;
            ce_cnt        <= LAT;
        end else if (ce_run) begin
            if (ce_cnt == 1) begin
                ce_run <= 1'b0;
                if (!mute) begin
                    bus.call_done   <= 1'b1;
                    bus.call_result <= ce_a * ce_b;
                end
            end else begin
                ce_cnt <= ce_cnt - 1;
            end
        end
    end

    // Monitor: compares operand launches and delivered results against the queues.
    always @(negedge clk) begin
        logic [2*WIDTH-1:0] eop;
        exp_t               e;
        if (reset) begin
            if (bus.call_start) begin
                n_start++;
                total++;
                if (op_q.size() == 0) begin
                    bad++;
                    $display("FAIL call_operands: unexpected start a=%0d b=%0d", bus.call_a, bus.call_b);
                end else begin
                    eop = op_q.pop_front();
                    if ({bus.call_a, bus.call_b} !== eop) begin
                        bad++;
                        $display("FAIL call_operands: got a=%0d b=%0d expected a=%0d b=%0d",
                                 bus.call_a, bus.call_b, eop[2*WIDTH-1:WIDTH], eop[WIDTH-1:0]);
                    end
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL result: unexpected output result=%0d error=%0b", bus.out_result, bus.out_error);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.out_result !== e.res || bus.out_error !== e.err) begin
                        bad++;
                        $display("FAIL result: got %0d err=%0b expected %0d err=%0b",
                                 bus.out_result, bus.out_error, e.res, e.err);
                    end else begin
                        $display("result %0d err=%0b ok", bus.out_result, bus.out_error);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit err);
        int  n = 0;
        bit  acc;
        exp_t e;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        do begin
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 2000);
        bus.in_valid = 1'b0;
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL push: a=%0d b=%0d not accepted in_ready=%0b", a, b, bus.in_ready);
        end else begin
            e.res = err ? '0 : a * b;
            e.err = err;
            exp_q.push_back(e);
            op_q.push_back({a, b});
            $display("push a=%0d b=%0d", a, b);
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || bus.busy) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (exp_q.size() != 0 || bus.busy) begin
            bad++;
            $display("FAIL %s: not idle after %0d cycles pending=%0d busy=%0b", name, n, exp_q.size(), bus.busy);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s0;
        int c;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;

        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",   bus.in_ready,   1);
        check("rst_call_start", bus.call_start, 0);
        check("rst_call_a",     bus.call_a,     0);
        check("rst_call_b",     bus.call_b,     0);
        check("rst_out_valid",  bus.out_valid,  0);
        check("rst_out_result", bus.out_result, 0);
        check("rst_out_error",  bus.out_error,  0);
        check("rst_busy",       bus.busy,       0);
        reset = 1'b1;

        // Single call
        push(1, 2, 0);
        wait_idle("single_idle", 100);
        check("single_starts", n_start, 1);

        // Queued calls
        s0 = n_start;
        push(1, 2, 0);
        push(7, 4, 0);
        push(3, 5, 0);
        wait_idle("queued_idle", 200);
        check("queued_starts", n_start - s0, 3);

        // Backpressure: one in flight plus a full FIFO
        bus.out_ready = 1'b0;
        push(10, 11, 0);
        push(12, 13, 0);
        push(100, 200, 0);
        push(65535, 65537, 0);
        push(3, 3, 0);
        bus.in_valid = 1'b1;
        bus.in_a     = 9;
        bus.in_b     = 9;
        repeat (10) @(posedge clk);
        #1;
        check("bp_in_ready",   bus.in_ready,   0);
        check("bp_out_valid",  bus.out_valid,  1);
        check("bp_out_result", bus.out_result, 110);
        bus.out_ready = 1'b1;
        push(9, 9, 0);
        wait_idle("bp_idle", 300);

        // Timeout, then a normal call behind it
        mute = 1'b1;
        push(5, 6, 1);
        push(3, 5, 0);
        c = 0;
        while (!bus.call_start && c < 20) begin
            @(posedge clk);
            #1;
            c++;
        end
        c = 0;
        while (!bus.out_valid && c < TIMEOUT + 20) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("timeout_latency", (c >= TIMEOUT) && (c <= TIMEOUT + 1), 1);
        check("timeout_error",   bus.out_error,  1);
        check("timeout_result",  bus.out_result, 0);
        mute = 1'b0;
        wait_idle("timeout_idle", 200);

        // Reset while a call waits with two entries queued
        mute = 1'b1;
        push(7, 8, 0);
        push(9, 10, 0);
        push(11, 12, 0);
        repeat (10) @(posedge clk);
        #1;
        check("midrst_busy_before", bus.busy, 1);
        reset = 1'b0;
        exp_q.delete();
        op_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        mute  = 1'b0;
        check("midrst_busy",     bus.busy,      0);
        check("midrst_in_ready", bus.in_ready,  1);
        check("midrst_valid",    bus.out_valid, 0);
        repeat (30) @(posedge clk);
        #1;
        check("midrst_busy_late",  bus.busy,      0);
        check("midrst_valid_late", bus.out_valid, 0);
        push(7, 4, 0);
        wait_idle("midrst_idle", 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
